// File: rtl/bitbang_target.sv
// SPI mode-0 target for the bitbang link: oversampled pins, MSB-first
// shift registers, show-ahead FIFO prefetch and a received-word strobe.
module bitbang_target #(
  parameter int W    = 16,
  parameter int SYNC = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         sck,
  input  logic         cs_n,
  input  logic         mosi,
  output logic         miso,
  input  logic [W-1:0] in,
  output logic         get,
  input  logic         empty,
  output logic [W-1:0] out,
  output logic         put,
  output logic         underrun
);

  localparam int CW = $clog2(W);

  typedef enum logic {
    IDLE,
    FRAME
  } state_t;

  state_t        state;
  logic [SYNC:0] sck_q;
  logic [SYNC:0] cs_q;
  logic [SYNC-1:0] mosi_q;
  logic [W-1:0]  hold;
  logic [W-1:0]  tx;
  logic [W-1:0]  rx;
  logic [CW-1:0] count;
  logic          hv;
  logic          last;

  logic sck_rise;
  logic sck_fall;
  logic cs_fall;
  logic cs_rise;
  logic mosi_s;
  logic live;
  logic load;

  assign sck_rise = sck_q[SYNC-1] & ~sck_q[SYNC];
  assign sck_fall = ~sck_q[SYNC-1] & sck_q[SYNC];
  assign cs_fall  = ~cs_q[SYNC-1] & cs_q[SYNC];
  assign cs_rise  = cs_q[SYNC-1] & ~cs_q[SYNC];
  assign mosi_s   = mosi_q[SYNC-1];

  // cs_rise wins over any sck edge seen in the same cycle
  assign live = (state == FRAME) & ~cs_rise;
  assign load = cs_fall | (live & sck_fall & last);
  assign miso = (state == FRAME) ? tx[W-1] : 1'b1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sck_q  <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[SYNC-1:0], sck};
      cs_q   <= {cs_q[SYNC-1:0], cs_n};
      mosi_q <= {mosi_q[SYNC-2:0], mosi};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      hold     <= '0;
      hv       <= 1'b0;
      tx       <= '1;
      rx       <= '0;
      count    <= '0;
      last     <= 1'b0;
      get      <= 1'b0;
      put      <= 1'b0;
      underrun <= 1'b0;
      out      <= '0;
    end else begin
      put      <= 1'b0;
      underrun <= 1'b0;
      get      <= ~hv & ~empty & ~get;

      // a completing pop refills hold even if a load drains it now
      if (get) begin
        hold <= in;
        hv   <= 1'b1;
      end else if (load) begin
        hv <= 1'b0;
      end

      if (load) begin
        tx       <= hv ? hold : '1;
        underrun <= ~hv;
      end else if (live & sck_fall) begin
        tx <= {tx[W-2:0], 1'b1};
      end

      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state <= FRAME;
          end
        end
        FRAME: begin
          if (cs_rise) begin
            state <= IDLE;
            count <= '0;
            last  <= 1'b0;
            rx    <= '0;
          end else if (sck_rise) begin
            rx <= {rx[W-2:0], mosi_s};
            if (count == CW'(W - 1)) begin
              count <= '0;
              out   <= {rx[W-2:0], mosi_s};
              put   <= 1'b1;
              last  <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end else if (sck_fall) begin
            last <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitbang_target.sv
// Bench for bitbang_target: bit-level SPI master, FIFO model and a
// word-level reference model of which word each load should present.
module tb_bitbang_target;

  localparam int W = 16;
  localparam int H = 6;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         sck = 1'b0;
  logic         cs_n = 1'b1;
  logic         mosi = 1'b0;
  logic         miso;
  logic [W-1:0] in = '0;
  logic         get;
  logic         empty = 1'b1;
  logic [W-1:0] out;
  logic         put;
  logic         underrun;

  int n_cmp = 0;
  int n_bad = 0;
  int n_get = 0;
  int n_und = 0;
  int get_err = 0;
  int rd = 0;
  int pr = 0;
  int exp_und = 0;

  logic [W-1:0] fifo_mem[$];
  logic [W-1:0] avail[$];
  logic [W-1:0] puts_q[$];

  bitbang_target #(.W(W), .SYNC(2)) dut (
    .clock(clock),
    .reset(reset),
    .sck(sck),
    .cs_n(cs_n),
    .mosi(mosi),
    .miso(miso),
    .in(in),
    .get(get),
    .empty(empty),
    .out(out),
    .put(put),
    .underrun(underrun)
  );

  always #5 clock = ~clock;

  // show-ahead FIFO and output monitor, sampled mid-cycle
  always @(negedge clock) begin
    if (get) begin
      n_get++;
      if (rd >= fifo_mem.size()) get_err++;
      else begin
        in = fifo_mem[rd];
        rd++;
      end
    end
    empty = (rd >= fifo_mem.size());
    if (put) puts_q.push_back(out);
    if (underrun) n_und++;
  end

  function automatic logic [W-1:0] model_load();
    if (avail.size() > 0) return avail.pop_front();
    exp_und++;
    return '1;
  endfunction

  task automatic push_word(input logic [W-1:0] w);
    fifo_mem.push_back(w);
    avail.push_back(w);
  endtask

  task automatic rebuild_avail();
    avail.delete();
    for (int i = rd; i < fifo_mem.size(); i++) avail.push_back(fifo_mem[i]);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    sck = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (2) @(negedge clock);
    rebuild_avail();
    reset = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    repeat (H) @(negedge clock);
  endtask

  task automatic cs_end();
    repeat (H) @(negedge clock);
    cs_n = 1'b1;
    repeat (2 * H) @(negedge clock);
  endtask

  task automatic send_bits(input logic [W-1:0] mo, input int nb,
                           output logic [W-1:0] mi);
    mi = '0;
    for (int i = W - 1; i >= W - nb; i--) begin
      mosi = mo[i];
      repeat (H) @(negedge clock);
      mi[i] = miso;
      sck = 1'b1;
      repeat (H) @(negedge clock);
      sck = 1'b0;
    end
  endtask

  task automatic test_reset();
    int g0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      {sck, cs_n, mosi} = 3'($urandom);
      @(negedge clock);
      n_cmp++;
      if ({get, put, underrun, miso, out} !== {4'b0001, 16'h0000}) begin
        n_bad++;
        $display("FAIL reset_state: got get=%b put=%b und=%b miso=%b out=%h want 0 0 0 1 0000",
                 get, put, underrun, miso, out);
      end
    end
    sck = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    rebuild_avail();
    reset = 1'b1;
    g0 = n_get;
    repeat (10) @(negedge clock);
    n_cmp++;
    if (n_get - g0 != 0) begin
      n_bad++;
      $display("FAIL reset_no_get: got %0d gets want 0", n_get - g0);
    end
    push_word(16'h5A5A);
    repeat (10) @(negedge clock);
    n_cmp++;
    if (n_get - g0 != 1) begin
      n_bad++;
      $display("FAIL reset_one_get: got %0d gets want 1", n_get - g0);
    end
  endtask

  task automatic check_puts(input logic [W-1:0] w, input string nm);
    n_cmp++;
    if (pr >= puts_q.size() || puts_q[pr] !== w) begin
      n_bad++;
      $display("FAIL %s_put: got %h (%0d pending) want %h", nm,
               (pr < puts_q.size()) ? puts_q[pr] : 16'hxxxx, puts_q.size() - pr, w);
    end
    if (pr < puts_q.size()) pr++;
  endtask

  task automatic test_single();
    logic [W-1:0] e, mi;
    int u0;
    apply_reset();
    u0 = n_und;
    exp_und = 0;
    push_word(16'h1234);
    push_word(16'($urandom));
    repeat (4) @(negedge clock);
    cs_begin();
    e = model_load();
    send_bits(16'hA5C3, W, mi);
    void'(model_load());
    cs_end();
    n_cmp++;
    if (mi !== e || e !== 16'h1234) begin
      n_bad++;
      $display("FAIL single_miso: got %h want %h", mi, e);
    end
    check_puts(16'hA5C3, "single");
    n_cmp++;
    if (puts_q.size() != pr || n_und - u0 != 0) begin
      n_bad++;
      $display("FAIL single_extra: got %0d extra puts %0d underruns want 0 0",
               puts_q.size() - pr, n_und - u0);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e0, e1, m0, m1;
    int u0, g0;
    apply_reset();
    u0 = n_und;
    g0 = n_get;
    exp_und = 0;
    push_word(16'h1111);
    push_word(16'h2222);
    push_word(16'($urandom));
    repeat (4) @(negedge clock);
    cs_begin();
    e0 = model_load();
    send_bits(16'hBEEF, W, m0);
    e1 = model_load();
    send_bits(16'h0F0F, W, m1);
    void'(model_load());
    cs_end();
    n_cmp++;
    if (m0 !== 16'h1111 || m1 !== 16'h2222 || m0 !== e0 || m1 !== e1) begin
      n_bad++;
      $display("FAIL b2b_miso: got %h %h want %h %h", m0, m1, e0, e1);
    end
    check_puts(16'hBEEF, "b2b0");
    check_puts(16'h0F0F, "b2b1");
    n_cmp++;
    if (n_get - g0 != 3 || n_und - u0 != exp_und) begin
      n_bad++;
      $display("FAIL b2b_counts: got gets=%0d und=%0d want 3 %0d",
               n_get - g0, n_und - u0, exp_und);
    end
  endtask

  task automatic test_underrun();
    logic [W-1:0] e, mi;
    int u0;
    apply_reset();
    u0 = n_und;
    exp_und = 0;
    cs_begin();
    e = model_load();
    n_cmp++;
    if (n_und - u0 != 1) begin
      n_bad++;
      $display("FAIL und_at_csfall: got %0d want 1", n_und - u0);
    end
    send_bits(16'h0001, W, mi);
    void'(model_load());
    cs_end();
    n_cmp++;
    if (mi !== 16'hFFFF || mi !== e) begin
      n_bad++;
      $display("FAIL und_miso: got %h want ffff", mi);
    end
    check_puts(16'h0001, "und");
    n_cmp++;
    if (n_und - u0 != exp_und) begin
      n_bad++;
      $display("FAIL und_count: got %0d want %0d", n_und - u0, exp_und);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] e, mi;
    int u0;
    apply_reset();
    u0 = n_und;
    exp_und = 0;
    push_word(16'($urandom));
    push_word(16'($urandom));
    repeat (4) @(negedge clock);
    cs_begin();
    e = model_load();
    send_bits(16'($urandom), 5, mi);
    cs_end();
    n_cmp++;
    if (mi[W-1:W-5] !== e[W-1:W-5] || puts_q.size() != pr) begin
      n_bad++;
      $display("FAIL abort_partial: got miso %b puts %0d want %b 0",
               mi[W-1:W-5], puts_q.size() - pr, e[W-1:W-5]);
    end
    repeat (4) @(negedge clock);
    cs_begin();
    e = model_load();
    send_bits(16'h8001, W, mi);
    void'(model_load());
    cs_end();
    n_cmp++;
    if (mi !== e) begin
      n_bad++;
      $display("FAIL abort_miso: got %h want %h", mi, e);
    end
    check_puts(16'h8001, "abort");
    n_cmp++;
    if (n_und - u0 != exp_und) begin
      n_bad++;
      $display("FAIL abort_und: got %0d want %0d", n_und - u0, exp_und);
    end
  endtask

  task automatic test_midreset();
    logic [W-1:0] e, mi, mo;
    int u0;
    apply_reset();
    push_word(16'($urandom));
    push_word(16'($urandom));
    repeat (4) @(negedge clock);
    cs_begin();
    void'(model_load());
    send_bits(16'($urandom), 8, mi);
    reset = 1'b0;
    cs_n = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({get, put, underrun, miso, out} !== {4'b0001, 16'h0000}) begin
      n_bad++;
      $display("FAIL midreset_state: got get=%b put=%b und=%b miso=%b out=%h want 0 0 0 1 0000",
               get, put, underrun, miso, out);
    end
    rebuild_avail();
    reset = 1'b1;
    repeat (2 * H) @(negedge clock);
    n_cmp++;
    if (puts_q.size() != pr) begin
      n_bad++;
      $display("FAIL midreset_noput: got %0d puts want 0", puts_q.size() - pr);
    end
    u0 = n_und;
    exp_und = 0;
    push_word(16'($urandom));
    repeat (4) @(negedge clock);
    mo = 16'($urandom);
    cs_begin();
    e = model_load();
    send_bits(mo, W, mi);
    void'(model_load());
    cs_end();
    n_cmp++;
    if (mi !== e) begin
      n_bad++;
      $display("FAIL midreset_miso: got %h want %h", mi, e);
    end
    check_puts(mo, "midreset");
    n_cmp++;
    if (n_und - u0 != exp_und) begin
      n_bad++;
      $display("FAIL midreset_und: got %0d want %0d", n_und - u0, exp_und);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e, mi;
    logic [W-1:0] mos[3];
    int u0, np, nw;
    u0 = n_und;
    exp_und = 0;
    for (int it = 0; it < 5; it++) begin
      np = $urandom_range(0, 3);
      nw = $urandom_range(1, 3);
      for (int k = 0; k < np; k++) push_word(16'($urandom));
      repeat (4) @(negedge clock);
      cs_begin();
      e = model_load();
      for (int k = 0; k < nw; k++) begin
        mos[k] = 16'($urandom);
        send_bits(mos[k], W, mi);
        n_cmp++;
        if (mi !== e) begin
          n_bad++;
          $display("FAIL rand_miso: iter %0d word %0d got %h want %h", it, k, mi, e);
        end
        e = model_load();
      end
      cs_end();
      for (int k = 0; k < nw; k++) check_puts(mos[k], "rand");
      n_cmp++;
      if (n_und - u0 != exp_und) begin
        n_bad++;
        $display("FAIL rand_und: iter %0d got %0d want %0d", it, n_und - u0, exp_und);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_midreset();
    test_random();
    n_cmp++;
    if (get_err != 0 || puts_q.size() != pr) begin
      n_bad++;
      $display("FAIL final: got %0d gets on empty, %0d stray puts want 0 0",
               get_err, puts_q.size() - pr);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bitbang_target.md
Name: bitbang_target

Overview:
- Responder end of the bitbang serial link: an SPI mode-0 target that is clocked by an external master through sck, cs_n and mosi, and drives miso.
- Received W-bit words are pushed to a sink using the out/put handshake.
- Transmit words are pulled from a show-ahead FIFO using the in/get/empty handshake.
- All link pins are oversampled in the single system clock domain.

Parameters:
W, 16, word width in bits; the link is MSB first.
SYNC, 2, number of synchroniser flops on sck, cs_n and mosi (minimum 2).

Ports:
clock  input  1  system clock; every flop is rising-edge triggered.
reset  input  1  synchronous, active-low reset.
sck  input  1  link clock from the master; asynchronous.
cs_n  input  1  link select from the master, active-low; asynchronous.
mosi  input  1  serial data from the master; asynchronous.
miso  output  1  serial data to the master.
in  input  W  transmit word from the FIFO; valid the cycle after get and held until the next get.
get  output  1  one-cycle pop request to the FIFO.
empty  input  1  FIFO has no word.
out  output  W  last complete received word.
put  output  1  one-cycle strobe: out holds a new word.
underrun  output  1  one-cycle strobe: a word load found no word available.

Behaviour:
- Reset (reset=0 at a clock edge), values on the next clock:
  - get=0, put=0, underrun=0, miso=1, out=0.
  - Bit count is 0, the holding register is marked empty, the frame is inactive, and the synchroniser flops are set to idle (sck=0, cs_n=1).
  - Reset asserted mid-frame aborts the frame silently, with no put.
- Synchronisation and edge detection:
  - sck, cs_n and mosi each pass through SYNC flops, plus one flop for edge detection.
  - Events: sck_rise, sck_fall, cs_fall, cs_rise.
  - The master must hold sck high and low for at least SYNC+2 clocks each. Timing outside this is not supported.
- Prefetch:
  - The holding register hold[W-1:0] has a valid flag hv.
  - get pulses for exactly one cycle when hv=0, empty=0, and get was not high in the previous cycle.
  - The cycle after get: hold<=in, hv<=1.
  - A load event clears hv in the same cycle. Get may then pulse in the next cycle.
- Load event:
  - Occurs on cs_fall, and on the sck_fall that follows the W-th sck_rise of a word while cs_n stays low.
  - If hv=1: tx<=hold.
  - Else: tx<=all-ones and underrun pulses one cycle.
- Transmit path:
  - miso = tx[W-1] while the frame is active, and 1 while cs_n is high.
  - On a non-load sck_fall: tx<={tx[W-2:0],1}.
- Receive path:
  - On sck_rise: rx<={rx[W-2:0], mosi_sync} and count<=count+1.
  - When count reaches W: out<=received word and put=1 for the following cycle; count wraps to 0.
- Back-to-back words within one cs_n low period are supported with no gap bits.
- cs_rise:
  - Frame goes inactive, count<=0, partial rx bits are discarded, and no put is issued.
  - A word already loaded into tx is lost. It is not returned to hold.
- Simultaneous events:
  - cs_rise and sck_rise in the same cycle: cs_rise wins and the bit is ignored.
  - A get completion and a load in the same cycle: the load uses the old hv value, and the new word goes to hold.
- Latency:
  - put is high 1 clock after the clock in which the W-th sck_rise is detected.
  - After a load, miso is valid within 1 clock.

Test Plan:
- Reset check: drive reset=0 for 3 clocks with random pins -> get, put and underrun are 0, miso=1, out=0. Release reset with cs_n=1 -> one get pulse only once empty goes to 0.
- Single frame, W=16: FIFO presents 0x1234; master sends 0xA5C3 with sck half-period 6 clocks -> master samples 0x1234 on miso MSB first; exactly one put with out=0xA5C3; no underrun.
- Back-to-back: FIFO holds 0x1111, 0x2222; master sends 0xBEEF, 0x0F0F in one cs_n low period -> miso carries 0x1111 then 0x2222; two put pulses with out=0xBEEF then out=0x0F0F; get pulses twice in total before the second load, plus one refill attempt.
- Underrun: empty=1 throughout; master sends 0x0001 -> miso reads 0xFFFF; underrun pulses exactly once at cs_fall; put with out=0x0001.
- Abort: cs_n rises after 5 sck_rise events, then a full frame 0x8001 follows -> no put for the partial frame; the next frame gives out=0x8001 with correct bit alignment.
- Mid-frame reset: reset=0 for 1 clock after 8 bits -> no put; outputs return to reset values; the next full frame is received correctly.
